// File: rtl/imm_pkg.sv
// Shared types and helpers for the immediate generator.
// Holds format encodings, RV32I/RV64I opcodes and the opcode-based format decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        FmtI     = 3'b000,
        FmtS     = 3'b001,
        FmtB     = 3'b010,
        FmtU     = 3'b011,
        FmtJ     = 3'b100,
        FmtShamt = 3'b101,
        FmtIll0  = 3'b110,
        FmtIll1  = 3'b111
    } imm_fmt_e;

    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    function automatic int unsigned shamt_width(input int unsigned xlen);
        return (xlen == 64) ? 6 : 5;
    endfunction

    function automatic imm_fmt_e decode_fmt(input logic [31:0] instr);
        imm_fmt_e fmt;
        case (instr[6:0])
            OpImm: begin
                // slli/srli/srai carry a shift amount, not a signed immediate
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101) begin
                    fmt = FmtShamt;
                end else begin
                    fmt = FmtI;
                end
            end
            OpLoad, OpJalr:  fmt = FmtI;
            OpStore:         fmt = FmtS;
            OpBranch:        fmt = FmtB;
            OpLui, OpAuipc:  fmt = FmtU;
            OpJal:           fmt = FmtJ;
            default:         fmt = FmtIll0;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/imm_format.sv
// Combinational immediate extraction for all base integer formats.
// Every format except SHAMT sign-extends from instr[31]; illegal formats yield zero with an error.
module imm_format
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm,
    output logic            src_err
);

    localparam int unsigned ShW = shamt_width(XLEN);

    logic [31:0] imm32;
    logic        unused_instr;

    assign unused_instr = ^instr[6:0];

    always_comb begin
        imm32   = '0;
        src_err = 1'b0;
        case (fmt)
            FmtI:     imm32 = {{20{instr[31]}}, instr[31:20]};
            FmtS:     imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FmtB:     imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            FmtU:     imm32 = {instr[31:12], 12'b0};
            FmtJ:     imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                               instr[30:21], 1'b0};
            FmtShamt: imm32[ShW-1:0] = instr[20 +: ShW];
            default:  src_err = 1'b1;
        endcase
    end

    // SHAMT has bit 31 clear, so a uniform sign-extension is correct for every format
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator with valid/ready stages and full backpressure.
// Define IMM_EXT_AUTO_DECODE_EN to derive the format from the opcode instead of imm_src.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm,
    output logic            src_err
);

    imm_fmt_e fmt;

`ifdef IMM_EXT_AUTO_DECODE_EN
    logic unused_imm_src;
    assign unused_imm_src = ^imm_src;
    always_comb fmt = decode_fmt(instr);
`else
    always_comb fmt = imm_fmt_e'(imm_src);
`endif

    logic [XLEN-1:0] fmt_imm;
    logic            fmt_err;

    imm_format #(
        .XLEN(XLEN)
    ) u_format (
        .instr  (instr),
        .fmt    (fmt),
        .imm    (fmt_imm),
        .src_err(fmt_err)
    );

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] err_q;
    logic [XLEN-1:0]   imm_q [STAGES];
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] stg_valid;
    logic [STAGES-1:0] stg_err;
    logic [XLEN-1:0]   stg_imm [STAGES];

    // Stage k advances if out_ready is high or any stage at or after k has a bubble
    always_comb begin
        adv = '0;
        for (int k = 0; k < STAGES; k++) begin
            adv[k] = out_ready;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k && !valid_q[j]) begin
                    adv[k] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        stg_valid    = '0;
        stg_err      = '0;
        stg_valid[0] = in_valid;
        stg_err[0]   = fmt_err;
        stg_imm[0]   = fmt_imm;
        for (int k = 1; k < STAGES; k++) begin
            stg_valid[k] = valid_q[k-1];
            stg_err[k]   = err_q[k-1];
            stg_imm[k]   = imm_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                imm_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_q[k] <= stg_valid[k];
                    // Payload only loads on a real item so an empty output keeps its last value
                    if (stg_valid[k]) begin
                        imm_q[k] <= stg_imm[k];
                        err_q[k] <= stg_err[k];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = valid_q[STAGES-1];
    assign imm       = imm_q[STAGES-1];
    assign src_err   = err_q[STAGES-1];

endmodule
